// File: rtl/roll_button_conditioner.sv
// Roll button synchroniser + debouncer: clean level plus press/release/long-press pulses.
// Press/release accepted DEBOUNCE_CYCLES+3 edges after the input settles; no backpressure, pulses are unconditional.
module roll_button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic held
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_PRESSED,
    S_RELEASE_WAIT
  } state_t;

  state_t state, state_nx;

  logic          ff1, b_s;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [HW-1:0] hcnt, hcnt_nx;
  logic          pressed_nx, press_pulse_nx, release_pulse_nx, long_press_nx, held_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ff1           <= 1'b1;
      b_s           <= 1'b1;
      state         <= S_RELEASED;
      dcnt          <= '0;
      hcnt          <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
    end else begin
      ff1           <= button_n;
      b_s           <= ff1;
      state         <= state_nx;
      dcnt          <= dcnt_nx;
      hcnt          <= hcnt_nx;
      pressed       <= pressed_nx;
      press_pulse   <= press_pulse_nx;
      release_pulse <= release_pulse_nx;
      long_press    <= long_press_nx;
      held          <= held_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RELEASED:     if (!b_s) state_nx = S_PRESS_WAIT;
      S_PRESS_WAIT: begin
        if (b_s)                state_nx = S_RELEASED;
        else if (dcnt == DLAST) state_nx = S_PRESSED;
      end
      S_PRESSED:      if (b_s) state_nx = S_RELEASE_WAIT;
      S_RELEASE_WAIT: begin
        if (!b_s)               state_nx = S_PRESSED;
        else if (dcnt == DLAST) state_nx = S_RELEASED;
      end
      default:        state_nx = S_RELEASED;
    endcase
  end

  // Bounces back to PRESSED keep hcnt/held untouched, so a glitch only delays long_press.
  always_comb begin
    dcnt_nx          = dcnt;
    hcnt_nx          = hcnt;
    pressed_nx       = pressed;
    held_nx          = held;
    press_pulse_nx   = 1'b0;
    release_pulse_nx = 1'b0;
    long_press_nx    = 1'b0;
    case (state)
      S_RELEASED: begin
        if (!b_s) dcnt_nx = '0;
      end
      S_PRESS_WAIT: begin
        if (!b_s) begin
          if (dcnt == DLAST) begin
            pressed_nx     = 1'b1;
            press_pulse_nx = 1'b1;
            hcnt_nx        = '0;
          end else begin
            dcnt_nx = dcnt + DW'(1);
          end
        end
      end
      S_PRESSED: begin
        if (b_s) begin
          dcnt_nx = '0;
        end else if (!held) begin
          if (hcnt == HLAST) begin
            long_press_nx = 1'b1;
            held_nx       = 1'b1;
          end else begin
            hcnt_nx = hcnt + HW'(1);
          end
        end
      end
      S_RELEASE_WAIT: begin
        if (b_s) begin
          if (dcnt == DLAST) begin
            pressed_nx       = 1'b0;
            held_nx          = 1'b0;
            release_pulse_nx = 1'b1;
          end else begin
            dcnt_nx = dcnt + DW'(1);
          end
        end
      end
      default: begin
        dcnt_nx = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_roll_button_conditioner.sv
// Randomised + directed bench for roll_button_conditioner; a run-length reference model
// feeds an expected-output queue that a separate monitor drains every cycle.
module tb_roll_button_conditioner;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic reset;
  logic button_n;
  logic pressed, press_pulse, release_pulse, long_press, held;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [4:0] exp_q[$];

  roll_button_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_n     (button_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press),
    .held         (held)
  );

  always #5 clk = ~clk;

  // Reference model: button seen through a two-sample delay, accepted after D+1
  // consecutive equal samples; hold time advances on back-to-back low samples.
  logic m_s1 = 1'b1, m_s2 = 1'b1, m_prev = 1'b1;
  int   m_zrun = 0, m_orun = 0, m_credits = 0;
  logic m_pressed = 1'b0, m_held = 1'b0;

  always @(posedge clk) begin
    logic smp, pp, rp, lp;
    pp = 1'b0; rp = 1'b0; lp = 1'b0;
    if (!reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_prev = 1'b1;
      m_zrun = 0; m_orun = 0; m_credits = 0;
      m_pressed = 1'b0; m_held = 1'b0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = button_n;
      if (smp == 1'b0) begin m_zrun++; m_orun = 0; end
      else             begin m_orun++; m_zrun = 0; end
      if (!m_pressed && smp == 1'b0 && m_zrun == D + 1) begin
        m_pressed = 1'b1; pp = 1'b1; m_credits = 0;
      end else if (m_pressed && smp == 1'b1 && m_orun == D + 1) begin
        m_pressed = 1'b0; m_held = 1'b0; rp = 1'b1;
      end else if (m_pressed && !m_held && smp == 1'b0 && m_prev == 1'b0) begin
        m_credits++;
        if (m_credits == L) begin lp = 1'b1; m_held = 1'b1; end
      end
      m_prev = smp;
    end
    exp_q.push_back({m_pressed, pp, rp, lp, m_held});
  end

  always @(posedge clk) begin
    logic [4:0] exp_v, act_v;
    #1;
    cycle++;
    act_v = {pressed, press_pulse, release_pulse, long_press, held};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty cycle=%0d got=%b", cycle, act_v);
    end else begin
      exp_v = exp_q.pop_front();
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL outputs cycle=%0d got {pressed,press,release,long,held}=%b expected=%b",
                 cycle, act_v, exp_v);
      end
    end
    checks++;
    if ((32'(press_pulse) + 32'(release_pulse) + 32'(long_press)) > 1) begin
      failures++;
      $display("FAIL pulse_exclusive cycle=%0d got=%b%b%b expected at most one high",
               cycle, press_pulse, release_pulse, long_press);
    end
  end

  task automatic drive(input logic b, input int n);
    repeat (n) begin
      button_n = b;
      @(negedge clk);
    end
  endtask

  task automatic hold_reset(input logic b, input int n);
    reset = 1'b0;
    drive(b, n);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    button_n = 1'b0;
    // reset with button held, then a fresh press after release of reset
    drive(1'b0, 3);
    reset = 1'b1;
    drive(1'b0, 12);
    drive(1'b1, 12);
    // clean press/release
    drive(1'b0, 29);
    drive(1'b1, 12);
    // press glitch
    drive(1'b0, 3);
    drive(1'b1, 10);
    // release glitch during a press
    drive(1'b0, 15);
    drive(1'b1, 3);
    drive(1'b0, 10);
    drive(1'b1, 12);
    // long press, held well beyond the first long_press
    drive(1'b0, 130);
    drive(1'b1, 12);
    // long press with a 2-cycle bounce at hold count 10
    drive(1'b0, 17);
    drive(1'b1, 2);
    drive(1'b0, 40);
    drive(1'b1, 12);
    // reset while pressed and held, button stays low
    drive(1'b0, 35);
    hold_reset(1'b0, 2);
    drive(1'b0, 12);
    drive(1'b1, 12);
    // minimal glitch lengths around the acceptance threshold
    for (int g = 1; g <= D + 2; g++) begin
      drive(1'b0, g);
      drive(1'b1, 8);
    end
    // random bursts with occasional resets
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 19) == 0) hold_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 9));
      if ($urandom_range(0, 9) == 0) drive(1'b0, $urandom_range(20, 35));
    end
    drive(1'b1, 12);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
